// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Package    : instr_pack
// Description: Shared types and constants for the 9-bit CPU pipeline.
// Revision   : 1.0
// ============================================================================
package instr_pack;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_OFF_W = 8;
  localparam int LUT_DEPTH = 4;

  localparam logic [8:0] NOP_INSTR = 9'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_jump_lut.sv
`default_nettype none
// ============================================================================
// Module     : jump_lut
// Description: 4-entry long-jump target table; synchronous write, async read.
// Revision   : 1.0
// ============================================================================
module jump_lut
  import instr_pack::*;
#(
  parameter int PC_W = DEF_PC_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [1:0]      widx,
  input  logic [PC_W-1:0] wdata,
  input  logic [1:0]      ridx,
  output logic [PC_W-1:0] rdata
);

  logic [PC_W-1:0] r_mem [LUT_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[widx] <= wdata;
    end
  end

  // Read sees the pre-write contents on a same-cycle write to the same entry.
  assign rdata = r_mem[ridx];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module     : fetch_unit
// Description: Instruction fetch stage: PC, branch/jump redirect, fetch reg.
//              Optional RUN-cycle counter enabled by FETCH_CYC_CNT_EN.
// Revision   : 1.0
// ============================================================================
module fetch_unit
  import instr_pack::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int OFF_W = DEF_OFF_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             done,
  input  logic             stall,
  output logic [PC_W-1:0]  instr_addr,
  input  logic [8:0]       instr_data,
  input  logic             br_taken,
  input  logic [OFF_W-1:0] br_off,
  input  logic             jmp_en,
  input  logic [1:0]       jmp_idx,
  input  logic             lut_we,
  input  logic [1:0]       lut_widx,
  input  logic [PC_W-1:0]  lut_wdata,
  output logic [8:0]       instr,
  output logic             instr_valid,
  output logic [PC_W-1:0]  exec_pc,
  output logic             running,
  output logic             halted,
  output logic [15:0]      cycle_count
);

  fetch_state      r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, r_exec_pc;
  logic [8:0]      r_instr;
  logic            r_valid;
  logic [PC_W-1:0] w_jmp_target, w_br_target;

  jump_lut #(.PC_W(PC_W)) u_jump_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .widx  (lut_widx),
    .wdata (lut_wdata),
    .ridx  (jmp_idx),
    .rdata (w_jmp_target)
  );

  assign w_br_target = r_exec_pc + {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (done)  w_state_nxt = HALT;
      HALT:    if (start) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= '0;
      r_exec_pc <= '0;
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
    end else if (r_state == RUN) begin
      if (done) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else if (!stall) begin
        if (jmp_en) begin
          r_pc    <= w_jmp_target;
          r_valid <= 1'b0;
        end else if (br_taken) begin
          r_pc    <= w_br_target;
          r_valid <= 1'b0;
        end else begin
          r_instr   <= instr_data;
          r_exec_pc <= r_pc;
          r_valid   <= 1'b1;
          r_pc      <= r_pc + 1'b1;
        end
      end
    end else if (start) begin
      // Entering RUN from IDLE or HALT always restarts at address 0.
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

`ifdef FETCH_CYC_CNT_EN
  logic [15:0] r_cyc_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc_cnt <= '0;
    end else if (r_state != RUN && w_state_nxt == RUN) begin
      r_cyc_cnt <= '0;
    end else if (r_state == RUN && r_cyc_cnt != 16'hFFFF) begin
      r_cyc_cnt <= r_cyc_cnt + 16'd1;
    end
  end

  assign cycle_count = r_cyc_cnt;
`else
  assign cycle_count = 16'd0;
`endif

  assign instr_addr  = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign exec_pc     = r_exec_pc;
  assign running     = (r_state == RUN);
  assign halted      = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module     : tb_fetch_unit
// Description: Directed table-driven bench for fetch_unit; memory holds mem[i]=i.
// Revision   : 1.0
// ============================================================================
module tb_fetch_unit;

  localparam int PC_W  = 10;
  localparam int OFF_W = 8;

  localparam int RST = 1, ST = 2, DN = 4, SL = 8, BR = 16, JP = 32, WE = 64;

  typedef struct {
    logic             rst, start, done, stall, br, jmp, we;
    logic [OFF_W-1:0] off;
    logic [1:0]       jidx, widx;
    logic [PC_W-1:0]  wdata;
    logic             e_run, e_halt, e_valid;
    logic [PC_W-1:0]  e_epc, e_addr;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset, start, done, stall, br_taken, jmp_en, lut_we;
  logic [OFF_W-1:0] br_off;
  logic [1:0]       jmp_idx, lut_widx;
  logic [PC_W-1:0]  lut_wdata, instr_addr, exec_pc;
  logic [8:0]       instr_data, instr;
  logic             instr_valid, running, halted;
  logic [15:0]      cycle_count;

  int errors = 0;
  int checks = 0;
  int exp_cc = 0;
  logic prev_run = 1'b0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  // Instruction memory model: word i holds i (low 9 bits).
  assign instr_data = instr_addr[8:0];

  fetch_unit #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .stall       (stall),
    .instr_addr  (instr_addr),
    .instr_data  (instr_data),
    .br_taken    (br_taken),
    .br_off      (br_off),
    .jmp_en      (jmp_en),
    .jmp_idx     (jmp_idx),
    .lut_we      (lut_we),
    .lut_widx    (lut_widx),
    .lut_wdata   (lut_wdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_pc     (exec_pc),
    .running     (running),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  function automatic vec_t mk(int ctl, int off, int jidx, int widx, int wdata,
                              int run, int halt, int valid, int epc, int addr);
    vec_t v;
    v.rst   = ctl[0];
    v.start = ctl[1];
    v.done  = ctl[2];
    v.stall = ctl[3];
    v.br    = ctl[4];
    v.jmp   = ctl[5];
    v.we    = ctl[6];
    v.off   = off[OFF_W-1:0];
    v.jidx  = jidx[1:0];
    v.widx  = widx[1:0];
    v.wdata = wdata[PC_W-1:0];
    v.e_run   = run[0];
    v.e_halt  = halt[0];
    v.e_valid = valid[0];
    v.e_epc   = epc[PC_W-1:0];
    v.e_addr  = addr[PC_W-1:0];
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset     = v.rst;
    start     = v.start;
    done      = v.done;
    stall     = v.stall;
    br_taken  = v.br;
    br_off    = v.off;
    jmp_en    = v.jmp;
    jmp_idx   = v.jidx;
    lut_we    = v.we;
    lut_widx  = v.widx;
    lut_wdata = v.wdata;
    @(posedge clk);
    #1;
    chk("running", idx, int'(running), int'(v.e_run));
    chk("halted", idx, int'(halted), int'(v.e_halt));
    chk("instr_valid", idx, int'(instr_valid), int'(v.e_valid));
    chk("instr_addr", idx, int'(instr_addr), int'(v.e_addr));
    if (v.e_valid) begin
      chk("exec_pc", idx, int'(exec_pc), int'(v.e_epc));
      chk("instr", idx, int'(instr), int'(v.e_epc) % 512);
    end else if (!v.e_run) begin
      chk("instr_idle", idx, int'(instr), 0);
    end
`ifdef FETCH_CYC_CNT_EN
    if (v.rst) exp_cc = 0;
    else if (!prev_run && v.e_run) exp_cc = 0;
    else if (prev_run && exp_cc < 65535) exp_cc++;
`else
    exp_cc = 0;
`endif
    prev_run = v.e_run;
    chk("cycle_count", idx, int'(cycle_count), exp_cc);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ctl        off  jidx widx wdata  run halt valid epc    addr
    tbl.push_back(mk(RST,      0,  0,   0,  0,      0,  0,   0,    0,     0));
    tbl.push_back(mk(RST,      0,  0,   0,  0,      0,  0,   0,    0,     0));
    tbl.push_back(mk(0,        0,  0,   0,  0,      0,  0,   0,    0,     0));
    tbl.push_back(mk(ST,       0,  0,   0,  0,      1,  0,   0,    0,     0));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    0,     1));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    1,     2));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    2,     3));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    3,     4));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    4,     5));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    5,     6));
    tbl.push_back(mk(BR,      -3,  0,   0,  0,      1,  0,   0,    0,     2));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    2,     3));
    tbl.push_back(mk(BR,      -1,  0,   0,  0,      1,  0,   0,    0,     1));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    1,     2));
    tbl.push_back(mk(BR,      -4,  0,   0,  0,      1,  0,   0,    0,  1021));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1, 1021,  1022));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1, 1022,  1023));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1, 1023,     0));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    0,     1));
    tbl.push_back(mk(WE,       0,  0,   2,  'h1A0,  1,  0,   1,    1,     2));
    // Jump reads lut[2] while it is being overwritten: old value wins.
    tbl.push_back(mk(JP|WE,    0,  2,   2,  'h055,  1,  0,   0,    0, 'h1A0));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1, 'h1A0, 'h1A1));
    tbl.push_back(mk(WE,       0,  0,   1,  'h300,  1,  0,   1, 'h1A1, 'h1A2));
    tbl.push_back(mk(JP|BR,    5,  1,   0,  0,      1,  0,   0,    0, 'h300));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1, 'h300, 'h301));
    tbl.push_back(mk(WE,       0,  0,   0,  7,      1,  0,   1, 'h301, 'h302));
    tbl.push_back(mk(JP,       0,  0,   0,  0,      1,  0,   0,    0,     7));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    7,     8));
    tbl.push_back(mk(SL,       0,  0,   0,  0,      1,  0,   1,    7,     8));
    tbl.push_back(mk(SL|BR,   -3,  0,   0,  0,      1,  0,   1,    7,     8));
    tbl.push_back(mk(SL|JP,    0,  1,   0,  0,      1,  0,   1,    7,     8));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    8,     9));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    9,    10));
    tbl.push_back(mk(DN|BR,   -3,  0,   0,  0,      0,  1,   0,    0,    10));
    tbl.push_back(mk(BR|JP|SL,-3,  1,   0,  0,      0,  1,   0,    0,    10));
    tbl.push_back(mk(0,        0,  0,   0,  0,      0,  1,   0,    0,    10));
    tbl.push_back(mk(ST,       0,  0,   0,  0,      1,  0,   0,    0,     0));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    0,     1));
    tbl.push_back(mk(WE,       0,  0,   3,  12,     1,  0,   1,    1,     2));
    tbl.push_back(mk(JP,       0,  3,   0,  0,      1,  0,   0,    0,    12));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,   12,    13));
    tbl.push_back(mk(RST,      0,  0,   0,  0,      0,  0,   0,    0,     0));
    tbl.push_back(mk(ST,       0,  0,   0,  0,      1,  0,   0,    0,     0));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    0,     1));
    // Every table entry must now read back as zero.
    tbl.push_back(mk(JP,       0,  3,   0,  0,      1,  0,   0,    0,     0));
    tbl.push_back(mk(JP,       0,  2,   0,  0,      1,  0,   0,    0,     0));
    tbl.push_back(mk(JP,       0,  1,   0,  0,      1,  0,   0,    0,     0));
    tbl.push_back(mk(JP,       0,  0,   0,  0,      1,  0,   0,    0,     0));
    tbl.push_back(mk(0,        0,  0,   0,  0,      1,  0,   1,    0,     1));

    foreach (tbl[i]) apply(tbl[i], i);

    // Hand sequence: done while stalled halts; reset beats a concurrent start.
    apply(mk(DN|SL, 0, 0, 0, 0, 0, 1, 0, 0, 1), 100);
    apply(mk(RST|ST, 0, 0, 0, 0, 0, 0, 0, 0, 0), 101);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 102);
    apply(mk(ST, 0, 0, 0, 0, 1, 0, 0, 0, 0), 103);
    apply(mk(SL, 0, 0, 0, 0, 1, 0, 0, 0, 0), 104);
    apply(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1), 105);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
